// File: rtl/add_seq_ctrl.sv
// Command-driven sequencer for the element-wise vector add path: streams operand
// reads, registers each sum and writes it to the result memory at one element per cycle.
module add_seq_ctrl #(
   parameter  int MEM_WIDTH = 32,
   parameter  int MEM_DEPTH = 8,
   localparam int AW        = $clog2(MEM_DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [AW-1:0]        cmd_src1_i,
   input  logic [AW-1:0]        cmd_src2_i,
   input  logic [AW-1:0]        cmd_dst_i,
   input  logic [AW:0]          cmd_len_i,
   output logic                 rd_en_o,
   output logic [AW-1:0]        rd1_addr_o,
   output logic [AW-1:0]        rd2_addr_o,
   input  logic [MEM_WIDTH-1:0] operand1_i,
   input  logic [MEM_WIDTH-1:0] operand2_i,
   output logic                 wr_en_o,
   output logic [AW-1:0]        wr_addr_o,
   output logic [MEM_WIDTH-1:0] wr_data_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 carry_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_nextState;
   logic [AW-1:0]        r_src1;
   logic [AW-1:0]        r_src2;
   logic [AW-1:0]        r_dst;
   logic [AW:0]          r_len;
   logic [AW-1:0]        r_rdCnt;
   logic [AW-1:0]        r_wrCnt;
   logic                 r_drainCnt;
   logic                 r_rdValid;
   logic                 r_wrEn;
   logic [AW-1:0]        r_wrAddr;
   logic [MEM_WIDTH-1:0] r_wrData;
   logic                 r_carry;
   logic                 w_handshake;
   logic                 w_rdEn;
   logic                 w_lastRead;
   logic [AW:0]          w_lenClamped;
   logic [MEM_WIDTH:0]   w_sum;

   assign w_handshake  = (r_state == S_IDLE) && cmd_valid_i;
   assign w_rdEn       = (r_state == S_RUN);
   assign w_lenClamped = (cmd_len_i > (AW+1)'(MEM_DEPTH)) ? (AW+1)'(MEM_DEPTH) : cmd_len_i;
   assign w_lastRead   = ({1'b0, r_rdCnt} == (r_len - (AW+1)'(1)));
   assign w_sum        = {1'b0, operand1_i} + {1'b0, operand2_i};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid_i) begin
               w_nextState = (w_lenClamped != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (w_lastRead) begin
               w_nextState = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_drainCnt) begin
               w_nextState = S_DONE;
            end
         end
         S_DONE: begin
            w_nextState = S_IDLE;
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Command fields are captured only on the handshake and held for the whole command.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_src1 <= '0;
         r_src2 <= '0;
         r_dst  <= '0;
         r_len  <= '0;
      end else if (w_handshake) begin
         r_src1 <= cmd_src1_i;
         r_src2 <= cmd_src2_i;
         r_dst  <= cmd_dst_i;
         r_len  <= w_lenClamped;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rdCnt    <= '0;
         r_drainCnt <= 1'b0;
      end else begin
         if (w_handshake) begin
            r_rdCnt <= '0;
         end else if (w_rdEn) begin
            r_rdCnt <= r_rdCnt + AW'(1);
         end
         r_drainCnt <= (r_state == S_DRAIN) ? ~r_drainCnt : 1'b0;
      end
   end

   // Read-valid trails rd_en by one cycle; the registered sum and its write strobe trail by two.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rdValid <= 1'b0;
         r_wrEn    <= 1'b0;
         r_wrAddr  <= '0;
         r_wrData  <= '0;
         r_wrCnt   <= '0;
         r_carry   <= 1'b0;
      end else begin
         r_rdValid <= w_rdEn;
         r_wrEn    <= r_rdValid;
         if (w_handshake) begin
            r_wrCnt <= '0;
            r_carry <= 1'b0;
         end else if (r_rdValid) begin
            r_wrData <= w_sum[MEM_WIDTH-1:0];
            r_wrAddr <= r_dst + r_wrCnt;
            r_wrCnt  <= r_wrCnt + AW'(1);
            r_carry  <= r_carry | w_sum[MEM_WIDTH];
         end
      end
   end

   assign cmd_ready_o = (r_state == S_IDLE);
   assign busy_o      = (r_state != S_IDLE);
   assign done_o      = (r_state == S_DONE);
   assign rd_en_o     = w_rdEn;
   assign rd1_addr_o  = w_rdEn ? (r_src1 + r_rdCnt) : '0;
   assign rd2_addr_o  = w_rdEn ? (r_src2 + r_rdCnt) : '0;
   assign wr_en_o     = r_wrEn;
   assign wr_addr_o   = r_wrAddr;
   assign wr_data_o   = r_wrData;
   assign carry_o     = r_carry;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl: a queue-based reference model predicts every
// read address, write and carry result; a negedge monitor retires them against the DUT.
module tb_add_seq_ctrl;

   localparam int MEM_WIDTH = 32;
   localparam int MEM_DEPTH = 8;
   localparam int AW        = 3;

   logic                 clk_i       = 1'b0;
   logic                 rst_ni      = 1'b0;
   logic                 cmd_valid_i = 1'b0;
   logic                 cmd_ready_o;
   logic [AW-1:0]        cmd_src1_i  = '0;
   logic [AW-1:0]        cmd_src2_i  = '0;
   logic [AW-1:0]        cmd_dst_i   = '0;
   logic [AW:0]          cmd_len_i   = '0;
   logic                 rd_en_o;
   logic [AW-1:0]        rd1_addr_o;
   logic [AW-1:0]        rd2_addr_o;
   logic [MEM_WIDTH-1:0] operand1_i  = '0;
   logic [MEM_WIDTH-1:0] operand2_i  = '0;
   logic                 wr_en_o;
   logic [AW-1:0]        wr_addr_o;
   logic [MEM_WIDTH-1:0] wr_data_o;
   logic                 busy_o;
   logic                 done_o;
   logic                 carry_o;

   typedef struct {
      logic [AW-1:0] a1;
      logic [AW-1:0] a2;
   } rd_t;

   typedef struct {
      logic [AW-1:0]        addr;
      logic [MEM_WIDTH-1:0] data;
   } wr_t;

   logic [MEM_WIDTH-1:0] mem1 [MEM_DEPTH];
   logic [MEM_WIDTH-1:0] mem2 [MEM_DEPTH];
   rd_t                  expRd[$];
   wr_t                  expWr[$];
   bit                   expCarry = 1'b0;
   int                   checks   = 0;
   int                   errors   = 0;

   add_seq_ctrl #(
      .MEM_WIDTH(MEM_WIDTH),
      .MEM_DEPTH(MEM_DEPTH)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .cmd_valid_i(cmd_valid_i),
      .cmd_ready_o(cmd_ready_o),
      .cmd_src1_i (cmd_src1_i),
      .cmd_src2_i (cmd_src2_i),
      .cmd_dst_i  (cmd_dst_i),
      .cmd_len_i  (cmd_len_i),
      .rd_en_o    (rd_en_o),
      .rd1_addr_o (rd1_addr_o),
      .rd2_addr_o (rd2_addr_o),
      .operand1_i (operand1_i),
      .operand2_i (operand2_i),
      .wr_en_o    (wr_en_o),
      .wr_addr_o  (wr_addr_o),
      .wr_data_o  (wr_data_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .carry_o    (carry_o)
   );

   always #5 clk_i = ~clk_i;

   // Synchronous-read operand memories: data appears the cycle after the read strobe.
   always @(posedge clk_i) begin
      if (rd_en_o) begin
         operand1_i <= mem1[rd1_addr_o];
         operand2_i <= mem2[rd2_addr_o];
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_ready"}, 64'(cmd_ready_o), 64'd1);
      checkOutput({tag, "_rd_en"}, 64'(rd_en_o), 64'd0);
      checkOutput({tag, "_rd1"}, 64'(rd1_addr_o), 64'd0);
      checkOutput({tag, "_rd2"}, 64'(rd2_addr_o), 64'd0);
      checkOutput({tag, "_wr_en"}, 64'(wr_en_o), 64'd0);
      checkOutput({tag, "_wr_addr"}, 64'(wr_addr_o), 64'd0);
      checkOutput({tag, "_wr_data"}, 64'(wr_data_o), 64'd0);
      checkOutput({tag, "_busy"}, 64'(busy_o), 64'd0);
      checkOutput({tag, "_done"}, 64'(done_o), 64'd0);
      checkOutput({tag, "_carry"}, 64'(carry_o), 64'd0);
   endtask

   // Monitor: every read strobe and write strobe retires the oldest prediction.
   always @(negedge clk_i) begin
      rd_t r;
      wr_t w;
      if (rst_ni) begin
         if (rd_en_o) begin
            if (expRd.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_read: actual rd1=%0d rd2=%0d required no read", rd1_addr_o, rd2_addr_o);
            end else begin
               r = expRd.pop_front();
               checkOutput("rd1_addr", 64'(rd1_addr_o), 64'(r.a1));
               checkOutput("rd2_addr", 64'(rd2_addr_o), 64'(r.a2));
            end
         end
         if (wr_en_o) begin
            if (expWr.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_write: actual addr=%0d data=0x%0h required no write", wr_addr_o, wr_data_o);
            end else begin
               w = expWr.pop_front();
               checkOutput("wr_addr", 64'(wr_addr_o), 64'(w.addr));
               checkOutput("wr_data", 64'(wr_data_o), 64'(w.data));
            end
         end
      end
   end

   // Present a command from a negedge, wait (bounded) for ready, then predict its results.
   task automatic applyStimulus(input int src1, input int src2, input int dst, input int len, output int waited);
      int          effLen;
      int          a1;
      int          a2;
      logic [63:0] s;
      wr_t         w;
      rd_t         r;
      waited      = 0;
      cmd_src1_i  = AW'(src1);
      cmd_src2_i  = AW'(src2);
      cmd_dst_i   = AW'(dst);
      cmd_len_i   = (AW+1)'(len);
      cmd_valid_i = 1'b1;
      while (!cmd_ready_o && waited < 50) begin
         @(negedge clk_i);
         waited++;
      end
      if (!cmd_ready_o) begin
         checks++;
         errors++;
         $display("[TB] FAIL handshake_timeout: actual ready=0 required ready=1 within 50 cycles");
      end
      @(posedge clk_i);
      effLen   = (len > MEM_DEPTH) ? MEM_DEPTH : len;
      expCarry = 1'b0;
      for (int k = 0; k < effLen; k++) begin
         a1     = (src1 + k) % MEM_DEPTH;
         a2     = (src2 + k) % MEM_DEPTH;
         s      = 64'(mem1[a1]) + 64'(mem2[a2]);
         r.a1   = AW'(a1);
         r.a2   = AW'(a2);
         w.addr = AW'((dst + k) % MEM_DEPTH);
         w.data = s[MEM_WIDTH-1:0];
         expCarry = expCarry | s[MEM_WIDTH];
         expRd.push_back(r);
         expWr.push_back(w);
      end
   endtask

   // Count cycles from the handshake to done and check the end-of-command state.
   task automatic waitDone(input int len);
      int effLen;
      int expDone;
      bit seen;
      effLen  = (len > MEM_DEPTH) ? MEM_DEPTH : len;
      expDone = (effLen == 0) ? 1 : effLen + 3;
      seen    = 1'b0;
      for (int n = 1; n <= expDone + 20; n++) begin
         @(negedge clk_i);
         if (n == 1) begin
            cmd_valid_i = 1'b0;
            checkOutput("busy_first_cycle", 64'(busy_o), 64'd1);
            checkOutput("carry_cleared", 64'(carry_o), 64'd0);
         end
         if (done_o) begin
            seen = 1'b1;
            checkOutput("done_cycle", 64'(n), 64'(expDone));
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: actual no done_o required done at cycle %0d", expDone);
      end
      checkOutput("carry", 64'(carry_o), 64'(expCarry));
      checkOutput("busy_at_done", 64'(busy_o), 64'd1);
      checkOutput("writes_retired", 64'(expWr.size()), 64'd0);
      checkOutput("reads_retired", 64'(expRd.size()), 64'd0);
      @(negedge clk_i);
      checkOutput("ready_after_done", 64'(cmd_ready_o), 64'd1);
      checkOutput("done_single_pulse", 64'(done_o), 64'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: actual simulation still running required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int waited;
      int rdSeen;
      for (int k = 0; k < MEM_DEPTH; k++) begin
         mem1[k] = 32'(k);
         mem2[k] = 32'(10 * k);
      end

      // Reset held with a pending command: nothing may be accepted.
      cmd_valid_i = 1'b1;
      cmd_len_i   = 4'd3;
      repeat (3) @(negedge clk_i);
      checkResetState("reset");
      cmd_valid_i = 1'b0;
      rst_ni      = 1'b1;
      @(negedge clk_i);
      checkOutput("idle_after_reset", 64'(busy_o), 64'd0);

      applyStimulus(0, 0, 0, 8, waited);
      waitDone(8);

      applyStimulus(6, 3, 7, 4, waited);
      waitDone(4);

      mem1[5] = 32'hFFFF_FFFF;
      mem2[2] = 32'h0000_0002;
      applyStimulus(5, 2, 4, 1, waited);
      waitDone(1);
      mem1[5] = 32'd5;
      mem2[2] = 32'd20;
      applyStimulus(5, 2, 4, 2, waited);
      waitDone(2);

      // len=0 followed immediately by len=2 with cmd_valid_i held high.
      applyStimulus(1, 1, 1, 0, waited);
      @(negedge clk_i);
      checkOutput("zero_len_done", 64'(done_o), 64'd1);
      checkOutput("zero_len_no_read", 64'(rd_en_o), 64'd0);
      applyStimulus(2, 5, 3, 2, waited);
      checkOutput("b2b_accept_delay", 64'(waited), 64'd1);
      waitDone(2);

      // Reset after the third read of a len=8 command.
      applyStimulus(0, 0, 0, 8, waited);
      rdSeen = 0;
      for (int n = 0; n < 20 && rdSeen < 3; n++) begin
         @(negedge clk_i);
         cmd_valid_i = 1'b0;
         if (rd_en_o) rdSeen++;
      end
      rst_ni = 1'b0;
      #1;
      expRd.delete();
      expWr.delete();
      checkResetState("mid_reset");
      repeat (3) begin
         @(negedge clk_i);
         checkOutput("in_reset_no_write", 64'(wr_en_o), 64'd0);
         checkOutput("in_reset_no_done", 64'(done_o), 64'd0);
      end
      rst_ni = 1'b1;
      repeat (4) begin
         @(negedge clk_i);
         checkOutput("post_reset_no_write", 64'(wr_en_o), 64'd0);
         checkOutput("post_reset_no_done", 64'(done_o), 64'd0);
         checkOutput("post_reset_ready", 64'(cmd_ready_o), 64'd1);
      end
      applyStimulus(3, 4, 5, 5, waited);
      waitDone(5);

      // Randomized commands, including lengths above MEM_DEPTH that must clamp.
      for (int t = 0; t < 24; t++) begin
         for (int k = 0; k < MEM_DEPTH; k++) begin
            mem1[k] = $urandom;
            mem2[k] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
         end
         applyStimulus(int'($urandom_range(0, MEM_DEPTH - 1)), int'($urandom_range(0, MEM_DEPTH - 1)),
                       int'($urandom_range(0, MEM_DEPTH - 1)), int'($urandom_range(0, 2 * MEM_DEPTH - 1)), waited);
         waitDone(int'(cmd_len_i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
